// File: rtl/monitor_read_ctrl.sv
// Periodic DDR read-out round controller for monitor_adaptor (ping-pong bank select, round/error counters).
// Define MONITOR_READ_CTRL_TIMEOUT_EN to build in the WAIT_FINISH completion watchdog.
module monitor_read_ctrl #(
    parameter int PERIOD_W    = 32,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    output logic                ddr_read_start,
    output logic                ddr_read_start_valid,
    input  logic                ddr_read_start_ready,
    input  logic                ddr_read_finish,
    input  logic                ddr_read_finish_valid,
    output logic                ddr_read_finish_ready,
    output logic                odd_even_flag,
    output logic                busy,
    output logic [CNT_W-1:0]    round_cnt,
    output logic                err_timeout,
    output logic [CNT_W-1:0]    err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PERIOD,
        ISSUE,
        WAIT_FINISH
    } state_t;

    state_t              state;
    logic [PERIOD_W-1:0] interval_cnt;
    logic [PERIOD_W-1:0] period_eff;
    logic                finish_done;

    always_comb begin
        period_eff  = (period == '0) ? PERIOD_W'(1) : period;
        finish_done = ddr_read_finish_valid && ddr_read_finish;
    end

    assign busy = (state == ISSUE) || (state == WAIT_FINISH);

`ifdef MONITOR_READ_CTRL_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;

    assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign err_timeout        = 1'b0;
    assign err_cnt            = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state                 <= IDLE;
            interval_cnt          <= '0;
            ddr_read_start        <= 1'b0;
            ddr_read_start_valid  <= 1'b0;
            ddr_read_finish_ready <= 1'b0;
            odd_even_flag         <= 1'b0;
            round_cnt             <= '0;
`ifdef MONITOR_READ_CTRL_TIMEOUT_EN
            wd_cnt                <= '0;
            err_timeout           <= 1'b0;
            err_cnt               <= '0;
`endif
        end else begin
`ifdef MONITOR_READ_CTRL_TIMEOUT_EN
            err_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (enable) begin
                        interval_cnt <= period_eff;
                        state        <= WAIT_PERIOD;
                    end
                end
                WAIT_PERIOD: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (interval_cnt == PERIOD_W'(1)) begin
                        odd_even_flag        <= ~odd_even_flag;
                        ddr_read_start       <= 1'b1;
                        ddr_read_start_valid <= 1'b1;
                        state                <= ISSUE;
                    end else begin
                        interval_cnt <= interval_cnt - PERIOD_W'(1);
                    end
                end
                ISSUE: begin
                    if (ddr_read_start_ready) begin
                        ddr_read_start        <= 1'b0;
                        ddr_read_start_valid  <= 1'b0;
                        ddr_read_finish_ready <= 1'b1;
                        state                 <= WAIT_FINISH;
`ifdef MONITOR_READ_CTRL_TIMEOUT_EN
                        wd_cnt                <= '0;
`endif
                    end
                end
                WAIT_FINISH: begin
                    // A finish=1 beat takes priority over a watchdog expiry in the same cycle.
                    if (finish_done) begin
                        round_cnt             <= round_cnt + CNT_W'(1);
                        ddr_read_finish_ready <= 1'b0;
                        interval_cnt          <= period_eff;
                        state                 <= enable ? WAIT_PERIOD : IDLE;
                    end
`ifdef MONITOR_READ_CTRL_TIMEOUT_EN
                    else if (wd_expire) begin
                        err_timeout           <= 1'b1;
                        if (err_cnt != '1)
                            err_cnt <= err_cnt + CNT_W'(1);
                        ddr_read_finish_ready <= 1'b0;
                        interval_cnt          <= period_eff;
                        state                 <= enable ? WAIT_PERIOD : IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/monitor_read_ctrl.md
Name: monitor_read_ctrl

Overview:
- Upstream controller for the monitor adaptor. Periodically commands one DDR read-out round through the ddr_read_start valid/ready handshake.
- Selects the ping-pong DDR bank through odd_even_flag and waits for the adaptor's ddr_read_finish handshake before the next round.
- Provides round/error counters and an optional completion watchdog.
- Sits between the card's control registers and monitor_adaptor.

Parameters:
- PERIOD_W, 32, width of the period register and the interval counter.
- CNT_W, 32, width of the round and error counters.
- TIMEOUT_CYC, 65536, maximum cycles in WAIT_FINISH before a timeout is declared (watchdog build only).

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- enable  in  1  level; 1 = run periodic rounds
- period  in  PERIOD_W  cycles between rounds; sampled on IDLE->WAIT_PERIOD and on every reload; 0 treated as 1
- ddr_read_start  out  1  start command bit
- ddr_read_start_valid  out  1  command valid
- ddr_read_start_ready  in  1  adaptor accepts command
- ddr_read_finish  in  1  finish status bit from adaptor
- ddr_read_finish_valid  in  1  finish status valid
- ddr_read_finish_ready  out  1  controller accepts finish status
- odd_even_flag  out  1  DDR bank the adaptor reads this round
- busy  out  1  1 in ISSUE or WAIT_FINISH
- round_cnt  out  CNT_W  completed rounds, wraps at 2^CNT_W
- err_timeout  out  1  one-cycle pulse on watchdog expiry
- err_cnt  out  CNT_W  timeouts, saturating

Behaviour:
- Reset (rst=1 at a clk edge, any state): state=IDLE. All outputs 0, including odd_even_flag, round_cnt, err_cnt, and the interval and watchdog counters. A round in flight is abandoned without a finish handshake.
- FSM states: IDLE, WAIT_PERIOD, ISSUE, WAIT_FINISH.
- IDLE:
  - enable=1 -> load interval counter with max(period,1); go to WAIT_PERIOD.
- WAIT_PERIOD:
  - Counter decrements each cycle.
  - Counter==1 -> toggle odd_even_flag (registered); go to ISSUE.
  - With period=N, ISSUE is entered N cycles after leaving IDLE/WAIT_FINISH.
  - enable=0 -> go to IDLE next cycle; odd_even_flag unchanged.
- ISSUE:
  - ddr_read_start=1 and ddr_read_start_valid=1, both registered; asserted the first cycle in ISSUE.
  - Held until ddr_read_start_ready=1 at a clk edge; AXI-style rule: valid never drops before acceptance.
  - On handshake: both drop next cycle; go to WAIT_FINISH; watchdog cleared.
  - enable=0 does not abort ISSUE.
- WAIT_FINISH:
  - ddr_read_finish_ready=1 every cycle in this state.
  - finish_valid=1 with finish=1 -> round_cnt+1; go to WAIT_PERIOD (reload period) if enable=1, else IDLE.
  - finish_valid=1 with finish=0 -> beat consumed and ignored; stay in WAIT_FINISH.
  - odd_even_flag is stable from ISSUE entry until the next WAIT_PERIOD exit.
- Outside WAIT_FINISH:
  - ddr_read_finish_ready=0.
  - Finish beats presented there are not consumed; they are accepted once WAIT_FINISH is reached.
- Simultaneous events:
  - Finish handshake and watchdog expiry in the same cycle: the finish wins; no error.
  - round_cnt wraps at its maximum.
  - err_cnt saturates at all-ones.
- busy: combinational decode of state ∈ {ISSUE, WAIT_FINISH}.

Optional Feature:
- Macro: MONITOR_READ_CTRL_TIMEOUT_EN.
- Defined:
  - Watchdog counts cycles in WAIT_FINISH.
  - Reaching TIMEOUT_CYC without a finish=1 handshake -> err_timeout pulses for 1 cycle; err_cnt+1; state goes to WAIT_PERIOD (enable=1) or IDLE.
  - odd_even_flag is not reverted, so the next round reads the other bank.
- Undefined:
  - No watchdog logic; WAIT_FINISH waits indefinitely.
  - err_timeout tied 0; err_cnt tied 0.

Test Plan:
1. Basic round: rst high 3 cycles, then enable=1, period=10; ready=1 constant; finish pulse 5 cycles after start accepted -> start_valid high on cycle 11 after enable for 1 cycle; odd_even_flag=1; round_cnt=1; second round flips flag to 0.
2. Backpressure: ready held 0 for 7 cycles in ISSUE -> start/start_valid held high 8 cycles; no second command issued; single accept.
3. Finish status: finish_valid with finish=0, then finish=1 3 cycles later -> first beat ignored; round_cnt increments once, on the finish=1 beat.
4. Enable drop: enable=0 mid WAIT_PERIOD -> IDLE next cycle, flag unchanged. Enable=0 during WAIT_FINISH -> round completes, then IDLE; round_cnt+1.
5. Watchdog (TIMEOUT_EN defined, TIMEOUT_CYC=16): no finish -> err_timeout pulse exactly 16 cycles after WAIT_FINISH entry; err_cnt=1; next round uses the toggled bank. With the macro undefined: remains in WAIT_FINISH, busy=1.
6. Reset mid-round: rst asserted in WAIT_FINISH -> next cycle all outputs 0, state IDLE; later finish_valid is not acknowledged (finish_ready=0).
